// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and controller state type for the inter-stage pipeline registers.
// Every stage builds its BUBBLE payload from INST_NOP so idle slots decode as a NOP.
package pipe_stage_reg_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;  // addi x0, x0, 0

    // Stage payload widths: IF/ID = {pc, inst}, ID/EX and EX/MEM carry decoded operands.
    localparam int unsigned IF_ID_W  = 64;
    localparam int unsigned ID_EX_W  = 32 + 32 + 32 + 32 + 5 + 1;
    localparam int unsigned EX_MEM_W = 32 + 32 + 5 + 1;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// One valid+data pipeline entry: synchronous reset, load, and clear-to-BUBBLE.
// Clear wins over load so the owner can kill a beat unconditionally.
module pipe_skid_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= load_data;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and an optional 2-entry skid buffer.
// With SKID=1 in_ready_o is a flop, so no combinational path runs from out_ready_i.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter bit                SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    logic              in_fire;
    logic              out_fire;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = m_valid & out_ready_i;
    assign out_valid_o = m_valid;
    assign out_data_o  = m_data;

    if (SKID) begin : g_skid
        skid_state_e       state_q, state_d;
        logic              ready_q;
        logic              m_load, m_clear, m_from_s;
        logic              s_load, s_clear, s_valid;
        logic [DATA_W-1:0] s_data;
        logic [DATA_W-1:0] m_src;

        always_comb begin
            state_d  = state_q;
            m_load   = 1'b0;
            m_clear  = 1'b0;
            m_from_s = 1'b0;
            s_load   = 1'b0;
            s_clear  = 1'b0;
            if (flush_i) begin
                state_d = StEmpty;
                m_clear = 1'b1;
                s_clear = 1'b1;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (in_fire) begin
                            state_d = StOne;
                            m_load  = 1'b1;
                        end
                    end
                    StOne: begin
                        if (in_fire && out_fire) begin
                            m_load = 1'b1;
                        end else if (in_fire) begin
                            state_d = StFull;
                            s_load  = 1'b1;
                        end else if (out_fire) begin
                            state_d = StEmpty;
                            m_clear = 1'b1;
                        end
                    end
                    StFull: begin
                        // in_ready_o is low here, so only the drain of M can happen.
                        if (out_fire) begin
                            state_d  = StOne;
                            m_load   = 1'b1;
                            m_from_s = 1'b1;
                            s_clear  = 1'b1;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= StEmpty;
                ready_q <= 1'b0;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != StFull);
            end
        end

        assign m_src = m_from_s ? s_data : in_data_i;

        pipe_skid_slot #(
            .DATA_W (DATA_W),
            .BUBBLE (BUBBLE)
        ) u_main (
            .clk       (clk),
            .rst       (rst),
            .load      (m_load),
            .clear     (m_clear),
            .load_data (m_src),
            .valid     (m_valid),
            .data      (m_data)
        );

        pipe_skid_slot #(
            .DATA_W (DATA_W),
            .BUBBLE (BUBBLE)
        ) u_skid (
            .clk       (clk),
            .rst       (rst),
            .load      (s_load),
            .clear     (s_clear),
            .load_data (in_data_i),
            .valid     (s_valid),
            .data      (s_data)
        );

        assign in_ready_o = ready_q;
        assign occ_o      = {1'b0, m_valid} + {1'b0, s_valid};
    end else begin : g_single
        logic m_load, m_clear;

        assign in_ready_o = ~m_valid | out_ready_i;
        assign m_load     = in_fire & ~flush_i;
        assign m_clear    = flush_i | (out_fire & ~in_fire);

        pipe_skid_slot #(
            .DATA_W (DATA_W),
            .BUBBLE (BUBBLE)
        ) u_main (
            .clk       (clk),
            .rst       (rst),
            .load      (m_load),
            .clear     (m_clear),
            .load_data (in_data_i),
            .valid     (m_valid),
            .data      (m_data)
        );

        assign occ_o = {1'b0, m_valid};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance against a FIFO-level model,
// plus directed reset/stream/stall/flush sequences on the skid build.
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned       W   = 32;
    localparam logic [W-1:0]      BUB = INST_NOP;

    logic         clk;
    logic         rst;
    logic         flush;
    logic [1:0]   in_valid;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready;
    logic [W-1:0] in_data  [2];
    logic [W-1:0] out_data [2];
    logic [1:0]   occ      [2];

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b1)) u_dut_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid[0]),
        .in_ready_o  (in_ready[0]),
        .in_data_i   (in_data[0]),
        .out_valid_o (out_valid[0]),
        .out_ready_i (out_ready[0]),
        .out_data_o  (out_data[0]),
        .occ_o       (occ[0])
    );

    pipe_stage_reg #(.DATA_W(W), .BUBBLE(BUB), .SKID(1'b0)) u_dut_single (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid[1]),
        .in_ready_o  (in_ready[1]),
        .in_data_i   (in_data[1]),
        .out_valid_o (out_valid[1]),
        .out_ready_i (out_ready[1]),
        .out_data_o  (out_data[1]),
        .occ_o       (occ[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Model: each stage is an in-order FIFO of capacity 2 (skid) or 1 (single).
    logic [W-1:0] mdat [2][4];
    int           mcnt [2];
    bit           mrdy;     // registered ready of the skid build
    bit           armed = 1'b0;
    bit           ev, er, fi, fo;
    logic [W-1:0] ed;

    initial begin
        mcnt[0] = 0;
        mcnt[1] = 0;
        mrdy    = 1'b0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ev = (mcnt[k] != 0);
            ed = ev ? mdat[k][0] : BUB;
            er = (k == 0) ? mrdy : ((mcnt[1] == 0) || out_ready[1]);
            if (armed) begin
                chk($sformatf("m%0d.out_valid", k), {31'b0, out_valid[k]}, {31'b0, ev});
                chk($sformatf("m%0d.out_data", k), out_data[k], ed);
                chk($sformatf("m%0d.occ", k), {30'b0, occ[k]}, mcnt[k]);
                chk($sformatf("m%0d.in_ready", k), {31'b0, in_ready[k]}, {31'b0, er});
            end
            fi = er & in_valid[k];
            fo = ev & out_ready[k];
            if (rst) begin
                mcnt[k] = 0;
                if (k == 0) mrdy = 1'b0;
            end else if (flush) begin
                mcnt[k] = 0;
                if (k == 0) mrdy = 1'b1;
            end else begin
                if (fo) begin
                    for (int j = 0; j < 3; j++) mdat[k][j] = mdat[k][j+1];
                    mcnt[k]--;
                end
                if (fi) begin
                    mdat[k][mcnt[k]] = in_data[k];
                    mcnt[k]++;
                end
                if (k == 0) mrdy = (mcnt[0] != 2);
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [W-1:0] d, input logic r, input logic f);
        in_valid[0]  = v;
        in_data[0]   = d;
        out_ready[0] = r;
        flush        = f;
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 2'b01;
        in_data[0]   = 32'hA5;
        in_data[1]   = 32'hA5;
        out_ready    = 2'b10;
        flush        = 1'b0;

        // Reset with a beat offered: it must be dropped.
        tick(); @(negedge clk);
        tick(); @(negedge clk);
        chk("rst.out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("rst.out_data", out_data[0], BUB);
        chk("rst.occ", {30'b0, occ[0]}, 32'd0);
        tick(); rst = 1'b0; in_valid[0] = 1'b0; @(negedge clk);
        tick(); @(negedge clk);
        chk("rst.in_ready", {31'b0, in_ready[0]}, 32'd1);
        chk("rst.in_ready_single", {31'b0, in_ready[1]}, 32'd1);
        chk("rst.dropped", {31'b0, out_valid[0]}, 32'd0);

        // Streaming 1..8 at full rate.
        for (int i = 1; i <= 9; i++) begin
            tick(); set0(i <= 8, i, 1'b1, 1'b0); @(negedge clk);
            if (i >= 2) begin
                chk("stream.data", out_data[0], i - 1);
                chk("stream.occ", {30'b0, occ[0]}, 32'd1);
            end
        end
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("stream.drained", {30'b0, occ[0]}, 32'd0);

        // Stall: two beats absorbed, third held off, then drained in order.
        tick(); set0(1'b1, 1, 1'b0, 1'b0); @(negedge clk);
        tick(); set0(1'b1, 2, 1'b0, 1'b0); @(negedge clk);
        chk("stall.one_ready", {31'b0, in_ready[0]}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); set0(1'b1, 3, 1'b0, 1'b0); @(negedge clk);
            chk("stall.full_ready", {31'b0, in_ready[0]}, 32'd0);
            chk("stall.full_occ", {30'b0, occ[0]}, 32'd2);
            chk("stall.held", out_data[0], 32'd1);
        end
        tick(); set0(1'b1, 3, 1'b1, 1'b0); @(negedge clk);
        chk("stall.out1", out_data[0], 32'd1);
        tick(); @(negedge clk);
        chk("stall.out2", out_data[0], 32'd2);
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("stall.out3", out_data[0], 32'd3);
        tick(); @(negedge clk);
        chk("stall.empty", {31'b0, out_valid[0]}, 32'd0);

        // Flush while FULL with 0x77 offered.
        tick(); set0(1'b1, 32'h11, 1'b0, 1'b0); @(negedge clk);
        tick(); set0(1'b1, 32'h22, 1'b0, 1'b0); @(negedge clk);
        tick(); set0(1'b1, 32'h77, 1'b0, 1'b1); @(negedge clk);
        chk("flushfull.occ_before", {30'b0, occ[0]}, 32'd2);
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("flushfull.valid", {31'b0, out_valid[0]}, 32'd0);
        chk("flushfull.data", out_data[0], BUB);
        chk("flushfull.occ", {30'b0, occ[0]}, 32'd0);
        chk("flushfull.ready", {31'b0, in_ready[0]}, 32'd1);
        tick(); @(negedge clk);
        chk("flushfull.no77", {31'b0, out_valid[0]}, 32'd0);

        // Flush while ONE with 0x77 actually firing: it must be discarded.
        tick(); set0(1'b1, 32'h33, 1'b0, 1'b0); @(negedge clk);
        tick(); set0(1'b1, 32'h77, 1'b0, 1'b1); @(negedge clk);
        chk("flushone.ready", {31'b0, in_ready[0]}, 32'd1);
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("flushone.valid", {31'b0, out_valid[0]}, 32'd0);
        tick(); @(negedge clk);
        chk("flushone.no77", {31'b0, out_valid[0]}, 32'd0);

        // Flush coinciding with out_fire: the beat is delivered once, then nothing.
        tick(); set0(1'b1, 32'h55, 1'b0, 1'b0); @(negedge clk);
        tick(); set0(1'b0, 0, 1'b1, 1'b1); @(negedge clk);
        chk("flushfire.data", out_data[0], 32'h55);
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("flushfire.after", {31'b0, out_valid[0]}, 32'd0);
        tick(); @(negedge clk);
        chk("flushfire.after2", {30'b0, occ[0]}, 32'd0);
        tick(); set0(1'b1, 32'h66, 1'b1, 1'b0); @(negedge clk);
        tick(); set0(1'b0, 0, 1'b1, 1'b0); @(negedge clk);
        chk("flushfire.new", out_data[0], 32'h66);

        // Random traffic on both builds; also probe ready against mid-cycle out_ready flips.
        for (int i = 0; i < 10000; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                in_data[k]   = $urandom;
                out_ready[k] = ((i / 250) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                    : ($urandom_range(0, 3) == 0);
            end
            flush = ($urandom_range(0, 96) == 0);
            #1;
            out_ready[0] = ~out_ready[0];
            #1;
            chk("comb_path", {31'b0, in_ready[0]}, {31'b0, mrdy});
            out_ready[0] = ~out_ready[0];
            @(negedge clk);
        end

        tick();
        in_valid  = 2'b00;
        out_ready = 2'b11;
        flush     = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain.occ0", {30'b0, occ[0]}, 32'd0);
        chk("drain.occ1", {30'b0, occ[1]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
